// File: rtl/demux_1an_regslice_if.sv
// demux_1an_regslice_if
//   Handshake bundle for the 1-to-NCH register-slice demultiplexer.
//   Upstream side:   valid_in, data_in, selector -> block; ready_in <- block
//   Downstream side: valid_out, data_out -> consumers; ready_out <- consumers
//   Status:          err_sel (sticky illegal-selector flag)
//   modport slave  : the demux itself
//   modport master : the environment driving the demux
interface demux_1an_regslice_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                  valid_in;
    logic [WIDTH-1:0]      data_in;
    logic [SELW-1:0]       selector;
    logic                  ready_in;
    logic [NCH-1:0]        valid_out;
    logic [NCH*WIDTH-1:0]  data_out;
    logic [NCH-1:0]        ready_out;
    logic                  err_sel;

    modport slave (
        input  valid_in, data_in, selector, ready_out,
        output ready_in, valid_out, data_out, err_sel
    );

    modport master (
        output valid_in, data_in, selector, ready_out,
        input  ready_in, valid_out, data_out, err_sel
    );
endinterface

// File: rtl/demux_1an_regslice.sv
// demux_1an_regslice
//   1-to-NCH demultiplexer with a valid/ready handshake and one registered
//   slot per output channel. Each accepted word is steered to the slot chosen
//   by selector; a full, stalled slot back-pressures only words addressed to
//   it. Words with an out-of-range selector are consumed, dropped, and set a
//   sticky error flag.
// Ports
//   clk      : rising-edge clock
//   reset_L  : asynchronous active-low reset (clears slots and err_sel)
//   bus      : demux_1an_regslice_if.slave handshake bundle
module demux_1an_regslice #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    demux_1an_regslice_if.slave   bus
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]             valid_q, valid_d;
    logic [NCH-1:0][WIDTH-1:0]  data_q,  data_d;
    logic                       err_q,   err_d;

    logic [NCH-1:0]             sel_hit;
    logic                       ready;
    logic                       accept;

    always_comb begin
        sel_hit = '0;
        // An unmatched (illegal) selector leaves ready at 1 so the word drains.
        ready   = 1'b1;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (bus.selector == SELW'(k)) begin
                sel_hit[k] = 1'b1;
                ready      = ~valid_q[k] | bus.ready_out[k];
            end
        end
        accept = bus.valid_in & ready;

        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q | (accept & ~(|sel_hit));
        for (int unsigned k = 0; k < NCH; k++) begin
            if (accept & sel_hit[k]) begin
                // Push wins over a same-cycle pop: old word leaves, new loads.
                valid_d[k] = 1'b1;
                data_d[k]  = bus.data_in;
            end else if (valid_q[k] & bus.ready_out[k]) begin
                // Pop only clears valid; the data slice is held.
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_demux_1an_regslice.sv
module tb_demux_1an_regslice;
    localparam int WIDTH = 4;
    localparam int NCH   = 3;

    logic clk = 1'b0;
    logic reset_L;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    demux_1an_regslice_if #(.WIDTH(WIDTH), .NCH(NCH)) dif ();

    demux_1an_regslice #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (dif)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
        dif.valid_in = v;
        dif.selector = s;
        dif.data_in  = d;
    endtask

    task automatic test_reset();
        dif.ready_out = 3'b000;
        drive(1'b1, 2'd0, 4'h9); step();
        drive(1'b1, 2'd2, 4'hB); step();
        drive(1'b1, 2'd3, 4'hF); step();
        drive(1'b0, 2'd0, 4'h0); #1;
        total++; if (dif.valid_out !== 3'b101) begin bad++; $display("FAIL reset_pre_valid got=%b exp=%b", dif.valid_out, 3'b101); end
        total++; if (dif.err_sel !== 1'b1) begin bad++; $display("FAIL reset_pre_err got=%b exp=1", dif.err_sel); end
        #1 reset_L = 1'b0;
        #1;
        total++; if (dif.valid_out !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b exp=000", dif.valid_out); end
        total++; if (dif.data_out !== 12'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", dif.data_out); end
        total++; if (dif.err_sel !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", dif.err_sel); end
        step();
        reset_L = 1'b1;
        dif.ready_out = 3'b111;
        drive(1'b1, 2'd1, 4'hA); #1;
        total++; if (dif.ready_in !== 1'b1) begin bad++; $display("FAIL reset_first_ready got=%b exp=1", dif.ready_in); end
        step();
        drive(1'b0, 2'd0, 4'h0);
        total++; if (dif.valid_out !== 3'b010) begin bad++; $display("FAIL reset_first_valid got=%b exp=010", dif.valid_out); end
        total++; if (dif.data_out[4 +: 4] !== 4'hA) begin bad++; $display("FAIL reset_first_data got=%h exp=a", dif.data_out[4 +: 4]); end
    endtask

    task automatic test_streaming();
        logic [3:0] exp;
        dif.ready_out = 3'b111;
        for (int i = 1; i <= 3; i++) begin
            exp = 4'(i);
            drive(1'b1, 2'd0, exp);
            step();
            total++; if (dif.data_out[0 +: 4] !== exp) begin bad++; $display("FAIL stream_data%0d got=%h exp=%h", i, dif.data_out[0 +: 4], exp); end
            total++; if (dif.valid_out[0] !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", i, dif.valid_out[0]); end
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        total++; if (dif.valid_out[0] !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b exp=0", dif.valid_out[0]); end
        total++; if (dif.data_out[0 +: 4] !== 4'h3) begin bad++; $display("FAIL stream_hold_data got=%h exp=3", dif.data_out[0 +: 4]); end
    endtask

    task automatic test_backpressure();
        dif.ready_out = 3'b011;
        drive(1'b1, 2'd2, 4'h5); step();
        drive(1'b1, 2'd2, 4'h6); #1;
        total++; if (dif.ready_in !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", dif.ready_in); end
        step();
        total++; if (dif.data_out[8 +: 4] !== 4'h5) begin bad++; $display("FAIL bp_hold_data got=%h exp=5", dif.data_out[8 +: 4]); end
        total++; if (dif.valid_out[2] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", dif.valid_out[2]); end
        drive(1'b1, 2'd0, 4'h7); #1;
        total++; if (dif.ready_in !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b exp=1", dif.ready_in); end
        step();
        total++; if (dif.data_out[0 +: 4] !== 4'h7) begin bad++; $display("FAIL bp_other_data got=%h exp=7", dif.data_out[0 +: 4]); end
        total++; if (dif.data_out[8 +: 4] !== 4'h5) begin bad++; $display("FAIL bp_still_data got=%h exp=5", dif.data_out[8 +: 4]); end
        dif.ready_out = 3'b111;
        drive(1'b1, 2'd2, 4'h6); #1;
        total++; if (dif.ready_in !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", dif.ready_in); end
        step();
        total++; if (dif.data_out[8 +: 4] !== 4'h6) begin bad++; $display("FAIL bp_release_data got=%h exp=6", dif.data_out[8 +: 4]); end
        total++; if (dif.valid_out[2] !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b exp=1", dif.valid_out[2]); end
        drive(1'b0, 2'd0, 4'h0);
        step();
    endtask

    task automatic test_pop_push();
        dif.ready_out = 3'b101;
        drive(1'b1, 2'd1, 4'hC); step();
        total++; if (dif.data_out[4 +: 4] !== 4'hC) begin bad++; $display("FAIL pp_load_data got=%h exp=c", dif.data_out[4 +: 4]); end
        dif.ready_out = 3'b111;
        drive(1'b1, 2'd1, 4'hD); #1;
        total++; if (dif.ready_in !== 1'b1) begin bad++; $display("FAIL pp_ready got=%b exp=1", dif.ready_in); end
        step();
        total++; if (dif.valid_out[1] !== 1'b1) begin bad++; $display("FAIL pp_valid got=%b exp=1", dif.valid_out[1]); end
        total++; if (dif.data_out[4 +: 4] !== 4'hD) begin bad++; $display("FAIL pp_data got=%h exp=d", dif.data_out[4 +: 4]); end
        drive(1'b0, 2'd0, 4'h0);
        step();
        total++; if (dif.valid_out[1] !== 1'b0) begin bad++; $display("FAIL pp_drain got=%b exp=0", dif.valid_out[1]); end
    endtask

    task automatic test_illegal_sel();
        dif.ready_out = 3'b000;
        drive(1'b1, 2'd0, 4'h8); step();
        drive(1'b1, 2'd3, 4'hF); #1;
        total++; if (dif.ready_in !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", dif.ready_in); end
        total++; if (dif.err_sel !== 1'b0) begin bad++; $display("FAIL ill_err_before got=%b exp=0", dif.err_sel); end
        step();
        drive(1'b0, 2'd0, 4'h0);
        total++; if (dif.valid_out !== 3'b001) begin bad++; $display("FAIL ill_valid got=%b exp=001", dif.valid_out); end
        total++; if (dif.data_out[0 +: 4] !== 4'h8) begin bad++; $display("FAIL ill_data got=%h exp=8", dif.data_out[0 +: 4]); end
        total++; if (dif.err_sel !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", dif.err_sel); end
        dif.ready_out = 3'b111;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'(i % 3), 4'(i));
            step();
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        total++; if (dif.err_sel !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", dif.err_sel); end
    endtask

    task automatic test_soak();
        logic [3:0] sbq [NCH][$];
        logic       err_exp;
        logic       rdy_exp;
        logic [3:0] got;
        int         sel;
        reset_L = 1'b0;
        drive(1'b0, 2'd0, 4'h0);
        dif.ready_out = 3'b000;
        step();
        reset_L = 1'b1;
        err_exp = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom));
            dif.ready_out = 3'($urandom);
            #1;
            sel = int'(dif.selector);
            rdy_exp = (sel >= NCH) ? 1'b1 : ((sbq[sel].size() == 0) || dif.ready_out[sel]);
            if (dif.valid_in) begin
                total++; if (dif.ready_in !== rdy_exp) begin bad++; $display("FAIL soak_ready cyc=%0d got=%b exp=%b", c, dif.ready_in, rdy_exp); end
            end
            for (int k = 0; k < NCH; k++) begin
                total++; if (dif.valid_out[k] !== (sbq[k].size() != 0)) begin bad++; $display("FAIL soak_valid cyc=%0d ch=%0d got=%b exp=%0d", c, k, dif.valid_out[k], sbq[k].size()); end
                if (dif.valid_out[k] && dif.ready_out[k]) begin
                    got = dif.data_out[k*WIDTH +: WIDTH];
                    if (sbq[k].size() == 0) begin
                        total++; bad++; $display("FAIL soak_dup cyc=%0d ch=%0d got=%h exp=none", c, k, got);
                    end else begin
                        total++; if (got !== sbq[k][0]) begin bad++; $display("FAIL soak_data cyc=%0d ch=%0d got=%h exp=%h", c, k, got, sbq[k][0]); end
                        void'(sbq[k].pop_front());
                    end
                end
            end
            total++; if (dif.err_sel !== err_exp) begin bad++; $display("FAIL soak_err cyc=%0d got=%b exp=%b", c, dif.err_sel, err_exp); end
            if (dif.valid_in && rdy_exp) begin
                if (sel < NCH) sbq[sel].push_back(dif.data_in);
                else err_exp = 1'b1;
            end
            step();
        end
        drive(1'b0, 2'd0, 4'h0);
        dif.ready_out = 3'b111;
        for (int k = 0; k < NCH; k++) if (sbq[k].size() != 0) void'(sbq[k].pop_front());
        step();
        total++; if (dif.valid_out !== 3'b000) begin bad++; $display("FAIL soak_final_valid got=%b exp=000", dif.valid_out); end
    endtask

    initial begin
        reset_L = 1'b0;
        dif.valid_in  = 1'b0;
        dif.selector  = 2'd0;
        dif.data_in   = 4'h0;
        dif.ready_out = 3'b000;
        step(); step();
        reset_L = 1'b1;
        step();
        test_reset();
        test_streaming();
        test_backpressure();
        test_pop_push();
        test_illegal_sel();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
